// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a requester and the apb_slave_mem completer.
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer: word-addressed register file with wait states,
// protocol-violation detection and a saturating violation counter.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  apb_slave_mem_if.slave apb,
  output logic [7:0]     viol_count
);
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int MEM_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            wait_q;
  logic                  stabErr_q;
  logic [7:0]            viol_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic             setupReq, accessReq, waitDone, mismatch;
  logic             busInRange, latInRange;
  logic             complete, latchSetup, incViol, doWrite;
  logic [IDX_W-1:0] busIdx, latIdx;
  logic [MEM_W-1:0] busMemIdx, latMemIdx;

  assign setupReq   = apb.PSEL & ~apb.PENABLE;
  assign accessReq  = apb.PSEL & apb.PENABLE;
  assign waitDone   = (wait_q == 4'd0);
  assign busIdx     = apb.PADDR[ADDR_WIDTH-1:2];
  assign latIdx     = addr_q[ADDR_WIDTH-1:2];
  assign busMemIdx  = MEM_W'(busIdx);
  assign latMemIdx  = MEM_W'(latIdx);
  assign busInRange = (32'(busIdx) < DEPTH);
  assign latInRange = (32'(latIdx) < DEPTH);

  // Write data only has to stay stable for writes; reads may leave PWDATA floating.
  assign mismatch   = (apb.PADDR != addr_q) || (apb.PWRITE != write_q) ||
                      (write_q && (apb.PWDATA != wdata_q));

  assign complete   = (state_q == ACCESS) && accessReq && waitDone;
  assign latchSetup = ((state_q == IDLE) || (state_q == ACCESS)) && setupReq;
  // A mismatch first seen on the completion edge cannot be flagged in PSLVERR
  // (outputs are registered) but still blocks the write.
  assign doWrite    = complete && write_q && !stabErr_q && !mismatch && latInRange;

  // Once stabErr_q is set the transfer has already been counted, so a later
  // abort or re-setup in the same transfer does not count again.
  always_comb begin
    incViol = 1'b0;
    case (state_q)
      IDLE:    incViol = accessReq;
      ACCESS:  incViol = !stabErr_q &&
                         (!apb.PSEL || setupReq || (accessReq && mismatch));
      default: incViol = 1'b0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setupReq) begin
          state_d = ACCESS;
        end else if (accessReq) begin
          state_d = ERR;
        end
      end
      ACCESS: begin
        if (!apb.PSEL || complete) begin
          state_d = IDLE;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    apb.PREADY  = 1'b0;
    apb.PSLVERR = 1'b0;
    apb.PRDATA  = rdata_q;
    case (state_q)
      ACCESS: begin
        apb.PREADY  = waitDone;
        apb.PSLVERR = waitDone && (stabErr_q || !latInRange);
      end
      ERR: begin
        apb.PREADY  = 1'b1;
        apb.PSLVERR = 1'b1;
      end
      default: begin
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wait_q    <= 4'd0;
      stabErr_q <= 1'b0;
    end else if (latchSetup) begin
      addr_q    <= apb.PADDR;
      write_q   <= apb.PWRITE;
      wdata_q   <= apb.PWDATA;
      wait_q    <= 4'(WAIT_STATES);
      stabErr_q <= 1'b0;
      if (!apb.PWRITE) begin
        rdata_q <= busInRange ? mem_q[busMemIdx] : '0;
      end
    end else if (state_q == ACCESS) begin
      if (!waitDone) begin
        wait_q <= wait_q - 4'd1;
      end
      if (accessReq && mismatch) begin
        stabErr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      viol_q <= 8'd0;
    end else if (incViol && (viol_q != 8'hFF)) begin
      viol_q <= viol_q + 8'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (doWrite) begin
      mem_q[latMemIdx] <= wdata_q;
    end
  end

  assign viol_count = viol_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three completers (0, 3 and 2 wait states)
// share one requester; tgt selects which one PSEL reaches and which is observed.
module tb_apb_slave_mem;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  int            tgt;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic [7:0]    viol, viol0, viol3, viol2;
  int            checks = 0;
  int            errors = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();
  apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  assign bus0.PSEL = psel && (tgt == 0);
  assign bus3.PSEL = psel && (tgt == 1);
  assign bus2.PSEL = psel && (tgt == 2);
  assign bus0.PENABLE = penable;
  assign bus3.PENABLE = penable;
  assign bus2.PENABLE = penable;
  assign bus0.PWRITE = pwrite;
  assign bus3.PWRITE = pwrite;
  assign bus2.PWRITE = pwrite;
  assign bus0.PADDR = paddr;
  assign bus3.PADDR = paddr;
  assign bus2.PADDR = paddr;
  assign bus0.PWDATA = pwdata;
  assign bus3.PWDATA = pwdata;
  assign bus2.PWDATA = pwdata;

  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .PCLK(pclk), .PRESETn(presetn), .apb(bus0), .viol_count(viol0));
  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .PCLK(pclk), .PRESETn(presetn), .apb(bus3), .viol_count(viol3));
  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64), .WAIT_STATES(2)) u_ws2 (
    .PCLK(pclk), .PRESETn(presetn), .apb(bus2), .viol_count(viol2));

  always_comb begin
    case (tgt)
      1: begin
        prdata = bus3.PRDATA; pready = bus3.PREADY; pslverr = bus3.PSLVERR; viol = viol3;
      end
      2: begin
        prdata = bus2.PRDATA; pready = bus2.PREADY; pslverr = bus2.PSLVERR; viol = viol2;
      end
      default: begin
        prdata = bus0.PRDATA; pready = bus0.PREADY; pslverr = bus0.PSLVERR; viol = viol0;
      end
    endcase
  end

  // Full transfer, entered and left at posedge+1; the next call starts its
  // setup in the cycle right after completion.
  task automatic apbXfer(input int t, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output logic [DW-1:0] rd,
                         output logic err, output int cycles, output int lowCycles);
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    cycles = 1; lowCycles = 0;
    @(posedge pclk); #1;
    penable = 1'b1; cycles = 2;
    while (!pready && cycles < 40) begin
      lowCycles++;
      @(posedge pclk); #1;
      cycles++;
    end
    if (!pready) begin
      checks++; errors++;
      $display("[TB] FAIL xfer_timeout addr=%h: PREADY got %b expected 1", a, pready);
    end
    rd = prdata; err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; tgt = 0;
    #22 presetn = 1'b1;
    @(posedge pclk); #1;
    checks++; if (pready !== 1'b0) begin errors++; $display("[TB] FAIL reset_pready got %b expected 0", pready); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("[TB] FAIL reset_pslverr got %b expected 0", pslverr); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_prdata got %h expected 0", prdata); end
    checks++; if (viol0 !== 8'd0) begin errors++; $display("[TB] FAIL reset_viol0 got %0d expected 0", viol0); end
    checks++; if (viol3 !== 8'd0) begin errors++; $display("[TB] FAIL reset_viol3 got %0d expected 0", viol3); end
    checks++; if (viol2 !== 8'd0) begin errors++; $display("[TB] FAIL reset_viol2 got %0d expected 0", viol2); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd; logic err; int cyc, low;
    apbXfer(0, 1'b1, 10'h010, 32'hDEADBEEF, rd, err, cyc, low);
    checks++; if (cyc != 2) begin errors++; $display("[TB] FAIL wr_cycles got %0d expected 2", cyc); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL wr_pslverr got %b expected 0", err); end
    apbXfer(0, 1'b0, 10'h010, 32'h0, rd, err, cyc, low);
    checks++; if (cyc != 2) begin errors++; $display("[TB] FAIL rd_cycles got %0d expected 2", cyc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_data got %h expected deadbeef", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rd_pslverr got %b expected 0", err); end
    checks++; if (viol !== 8'd0) begin errors++; $display("[TB] FAIL rd_viol got %0d expected 0", viol); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd; logic err; int cyc, low;
    apbXfer(0, 1'b1, 10'h020, 32'hCAFEF00D, rd, err, cyc, low);
    apbXfer(0, 1'b1, 10'h024, 32'h0BADF00D, rd, err, cyc, low);
    apbXfer(0, 1'b0, 10'h024, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL b2b_rd24 got %h expected 0badf00d", rd); end
    apbXfer(0, 1'b0, 10'h020, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL b2b_rd20 got %h expected cafef00d", rd); end
  endtask

  task automatic test_wait_states();
    logic [DW-1:0] rd; logic err; int cyc, low;
    apbXfer(1, 1'b1, 10'h004, 32'h12345678, rd, err, cyc, low);
    checks++; if (cyc != 5) begin errors++; $display("[TB] FAIL ws_wr_cycles got %0d expected 5", cyc); end
    checks++; if (low != 3) begin errors++; $display("[TB] FAIL ws_wr_low got %0d expected 3", low); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL ws_wr_pslverr got %b expected 0", err); end
    apbXfer(1, 1'b0, 10'h004, 32'h0, rd, err, cyc, low);
    checks++; if (cyc != 5) begin errors++; $display("[TB] FAIL ws_rd_cycles got %0d expected 5", cyc); end
    checks++; if (low != 3) begin errors++; $display("[TB] FAIL ws_rd_low got %0d expected 3", low); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("[TB] FAIL ws_rd_data got %h expected 12345678", rd); end
  endtask

  task automatic test_setup_violation();
    logic [DW-1:0] rd; logic err; int cyc, low;
    tgt = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 10'h008; pwdata = 32'h55;
    @(posedge pclk); #1;
    checks++; if (pready !== 1'b1) begin errors++; $display("[TB] FAIL sv_pready got %b expected 1", pready); end
    checks++; if (pslverr !== 1'b1) begin errors++; $display("[TB] FAIL sv_pslverr got %b expected 1", pslverr); end
    checks++; if (viol !== 8'd1) begin errors++; $display("[TB] FAIL sv_viol got %0d expected 1", viol); end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    checks++; if (pready !== 1'b0) begin errors++; $display("[TB] FAIL sv_err_one_cycle got %b expected 0", pready); end
    apbXfer(0, 1'b0, 10'h008, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL sv_readback got %h expected 0", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL sv_readback_err got %b expected 0", err); end
  endtask

  task automatic test_range_error();
    logic [DW-1:0] rd; logic err; int cyc, low;
    apbXfer(0, 1'b1, 10'h100, 32'hA5A5A5A5, rd, err, cyc, low);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL rng_wr_pslverr got %b expected 1", err); end
    checks++; if (viol !== 8'd1) begin errors++; $display("[TB] FAIL rng_viol got %0d expected 1", viol); end
    apbXfer(0, 1'b0, 10'h100, 32'h0, rd, err, cyc, low);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL rng_rd_pslverr got %b expected 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rng_rd_data got %h expected 0", rd); end
    apbXfer(0, 1'b0, 10'h000, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rng_alias0 got %h expected 0", rd); end
    apbXfer(0, 1'b0, 10'h0FC, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rng_top got %h expected 0", rd); end
    apbXfer(0, 1'b0, 10'h010, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rng_keep10 got %h expected deadbeef", rd); end
  endtask

  task automatic test_stability();
    logic [DW-1:0] rd; logic err; int cyc, low;
    tgt = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h00C; pwdata = 32'h11111111;
    @(posedge pclk); #1;
    penable = 1'b1;
    checks++; if (pready !== 1'b0) begin errors++; $display("[TB] FAIL stab_wait got %b expected 0", pready); end
    @(posedge pclk); #1;
    paddr = 10'h010;
    cyc = 0;
    while (!pready && cyc < 10) begin
      @(posedge pclk); #1;
      cyc++;
    end
    checks++; if (pslverr !== 1'b1) begin errors++; $display("[TB] FAIL stab_pslverr got %b expected 1", pslverr); end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    checks++; if (viol !== 8'd1) begin errors++; $display("[TB] FAIL stab_viol got %0d expected 1", viol); end
    apbXfer(2, 1'b0, 10'h00C, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL stab_rd0c got %h expected 0", rd); end
    apbXfer(2, 1'b0, 10'h010, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL stab_rd10 got %h expected 0", rd); end
  endtask

  task automatic test_abort();
    logic [DW-1:0] rd; logic err; int cyc, low;
    tgt = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h020; pwdata = 32'h99;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    checks++; if (viol !== 8'd2) begin errors++; $display("[TB] FAIL abort_viol got %0d expected 2", viol); end
    checks++; if (pready !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle got %b expected 0", pready); end
    apbXfer(2, 1'b0, 10'h020, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL abort_rd got %h expected 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic err; int cyc, low;
    tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h014; pwdata = 32'h77777777;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 presetn = 1'b0;
    #1;
    checks++; if (pready !== 1'b0) begin errors++; $display("[TB] FAIL rst_pready got %b expected 0", pready); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("[TB] FAIL rst_pslverr got %b expected 0", pslverr); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_prdata got %h expected 0", prdata); end
    checks++; if (viol !== 8'd0) begin errors++; $display("[TB] FAIL rst_viol got %0d expected 0", viol); end
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk); #1;
    apbXfer(0, 1'b0, 10'h014, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_rd14 got %h expected 0", rd); end
    apbXfer(0, 1'b0, 10'h010, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_rd10 got %h expected 0", rd); end
    apbXfer(0, 1'b1, 10'h018, 32'h13579BDF, rd, err, cyc, low);
    apbXfer(0, 1'b0, 10'h018, 32'h0, rd, err, cyc, low);
    checks++; if (rd !== 32'h13579BDF) begin errors++; $display("[TB] FAIL rst_after got %h expected 13579bdf", rd); end
    checks++; if (cyc != 2) begin errors++; $display("[TB] FAIL rst_after_cycles got %0d expected 2", cyc); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_setup_violation();
    test_range_error();
    test_stability();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB3 completer (slave) with a word-addressed register file, programmable wait-state insertion and protocol-violation detection. It is the responder end of the bus that the APB testbench driver initiates on. It answers the violation-injection tests, including PENABLE-without-setup, with PSLVERR instead of corrupting storage. A saturating violation counter lets the scoreboard cross-check how many violations the completer detected.

## Interface
Parameters:
- ADDR_WIDTH, 8, PADDR width in bits; byte address, word-aligned.
- DATA_WIDTH, 32, PWDATA/PRDATA width.
- DEPTH, 64, number of DATA_WIDTH words; word index = PADDR >> 2.
- WAIT_STATES, 0, PREADY-low cycles inserted in every access phase (0..15).

Ports:
- PCLK  in  1  bus clock; all state changes on rising edge.
- PRESETn  in  1  reset, asynchronous and active-low.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data, valid while PREADY=1 on a read.
- PREADY  out  1  transfer-complete indication.
- PSLVERR  out  1  error response, valid only while PREADY=1.
- viol_count  out  8  saturating count of detected violations.

## Operation
- FSM has three states: IDLE, ACCESS, ERR. Every output is a function of registered state.
- IDLE:
  - PSEL=1, PENABLE=0 sampled: latch PADDR, PWRITE and PWDATA; load the wait counter with WAIT_STATES; go to ACCESS.
  - Read: PRDATA is loaded from mem[index] on the same edge. It loads 0 if the index is out of range.
  - PSEL=1, PENABLE=1 sampled: setup violation. Increment viol_count; go to ERR. No latch, no write.
  - PSEL=0: stay in IDLE.
- ACCESS:
  - PREADY = (wait counter == 0). The counter decrements each cycle while nonzero.
  - Completion edge is PSEL=1, PENABLE=1, PREADY=1 sampled. Perform the write if PWRITE was latched and there is no error; return to IDLE.
  - Stability error: PADDR, PWRITE or (for writes) PWDATA differs from the latched value in any ACCESS cycle. The error is sticky until completion and increments viol_count once per transfer. PSLVERR=1 at completion; the write is suppressed.
  - Range error: index >= DEPTH gives PSLVERR=1; the write is suppressed and PRDATA=0. This is not counted as a protocol violation.
  - PSEL falls before completion (abort): go to IDLE with no write; increment viol_count.
  - PENABLE=0 with PSEL=1 in ACCESS is treated as an abort followed by a new setup. Increment viol_count; latch the new setup and stay in ACCESS.
- ERR: PREADY=1 and PSLVERR=1 for exactly one cycle, then IDLE unconditionally.
- PSLVERR=0 whenever PREADY=0. PRDATA holds its value outside transfers. PRDATA is unchanged by writes.
- viol_count saturates at 255. If a stability error and an abort coincide, viol_count increments by 1, not 2.

## Timing
- Reset (asynchronous, any state, including mid-transfer): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, viol_count=0, all mem words=0, wait counter=0. A pending write is discarded.
- Zero-wait transfer: setup cycle T1, then access cycle T2 with PREADY=1. The write is committed at the end of T2. PRDATA is valid throughout T2.
- With WAIT_STATES=N, the access phase lasts N+1 cycles and PREADY rises in cycle N+1.
- Back-to-back: the cycle after completion is sampled in IDLE, so a new setup there is accepted with no bubble.
- A read of the address written in the previous transfer returns the new data.
- Setup violation: the ERR response (PREADY=1, PSLVERR=1) appears the cycle after the violating sample.

## Test plan
- Write 0xDEADBEEF to 0x10, then read 0x10 with WAIT_STATES=0: each transfer is 2 cycles, PRDATA=0xDEADBEEF, PSLVERR=0 and viol_count=0.
- WAIT_STATES=3, write then read 0x04: PREADY is low for 3 access cycles and high on the 4th. Read data matches and the transfers take 5 cycles each.
- Drive PSEL=1, PENABLE=1 from idle with a write of 0x55 to 0x08: next cycle PREADY=1 and PSLVERR=1, viol_count=1, and a readback of 0x08 returns 0.
- Write to 0x100 (index 64, DEPTH=64): PSLVERR=1 at completion, viol_count unchanged, and no word in mem is modified.
- Change PADDR from 0x0C to 0x10 mid-access with WAIT_STATES=2: PSLVERR=1, both addresses read back 0, and viol_count increments by 1.
- Assert PRESETn low during the access phase of a write to 0x14, then release: outputs are at reset values, 0x14 reads 0, and the next transfer completes normally.
